// File: rtl/tx_control_unit.sv
// -----------------------------------------------------------------------------
// tx_control_unit
//
// Transmit control unit for the SD-to-USB interface. On a request from the
// protocol controller it presents the packet bytes to the downstream transmit
// shifter: SYNC, then PID, then (data packets only) a payload phase during
// which bytes are streamed from the SD/FIFO path instead of from this block.
//
// Ports
//   clk           system clock, rising-edge active
//   n_rst         asynchronous reset, active-high (name kept from the codebase)
//   tx_transmit   request: send a data packet
//   tx_send_good  request: send an ACK handshake packet
//   tx_send_bad   request: send a NAK handshake packet
//   load_enable   one-cycle strobe from the shifter: current byte was taken
//   empty         payload source has no more bytes
//   data          byte presented to the shifter (SYNC/PID), 8'h00 otherwise
//   sending       high while a packet is in progress
//   sd_enable     high during the payload phase
// -----------------------------------------------------------------------------
module tx_control_unit #(
   parameter logic [7:0] SYNC_BYTE = 8'h80,
   parameter logic [7:0] DATA_PID  = 8'hC3,
   parameter logic [7:0] ACK_PID   = 8'hD2,
   parameter logic [7:0] NAK_PID   = 8'h5A
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       tx_transmit,
   input  logic       tx_send_good,
   input  logic       tx_send_bad,
   input  logic       load_enable,
   input  logic       empty,
   output logic [7:0] data,
   output logic       sending,
   output logic       sd_enable
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SYNC    = 2'd1,
      PID     = 2'd2,
      PAYLOAD = 2'd3
   } state_t;

   state_t     state;
   logic [7:0] pid_q;
   logic       is_data_q;

   // Outputs are registered alongside the state so that they always equal the
   // decode of the state being entered; they only move on a clock edge or on
   // the asynchronous reset.
   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         state     <= IDLE;
         pid_q     <= DATA_PID;
         is_data_q <= 1'b0;
         data      <= 8'h00;
         sending   <= 1'b0;
         sd_enable <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // Priority: NAK over ACK over data. Lower-priority requests
               // arriving together are dropped, not queued.
               if (tx_send_bad || tx_send_good || tx_transmit) begin
                  state   <= SYNC;
                  data    <= SYNC_BYTE;
                  sending <= 1'b1;
                  if (tx_send_bad) begin
                     pid_q     <= NAK_PID;
                     is_data_q <= 1'b0;
                  end else if (tx_send_good) begin
                     pid_q     <= ACK_PID;
                     is_data_q <= 1'b0;
                  end else begin
                     pid_q     <= DATA_PID;
                     is_data_q <= 1'b1;
                  end
               end
            end

            SYNC: begin
               if (load_enable) begin
                  state <= PID;
                  data  <= pid_q;
               end
            end

            PID: begin
               if (load_enable) begin
                  // A data packet with nothing queued is sent zero-length.
                  if (is_data_q && !empty) begin
                     state     <= PAYLOAD;
                     data      <= 8'h00;
                     sd_enable <= 1'b1;
                  end else begin
                     state   <= IDLE;
                     data    <= 8'h00;
                     sending <= 1'b0;
                  end
               end
            end

            PAYLOAD: begin
               // Payload bytes are consumed downstream; only running out of
               // bytes ends the packet, regardless of load_enable.
               if (empty) begin
                  state     <= IDLE;
                  sending   <= 1'b0;
                  sd_enable <= 1'b0;
               end
            end

            default: begin
               state     <= IDLE;
               data      <= 8'h00;
               sending   <= 1'b0;
               sd_enable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_control_unit.sv
module tb_tx_control_unit;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       tx_transmit, tx_send_good, tx_send_bad, load_enable, empty;
   logic [7:0] data;
   logic       sending, sd_enable;

   always #5 clk = ~clk;

   tx_control_unit dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .tx_transmit  (tx_transmit),
      .tx_send_good (tx_send_good),
      .tx_send_bad  (tx_send_bad),
      .load_enable  (load_enable),
      .empty        (empty),
      .data         (data),
      .sending      (sending),
      .sd_enable    (sd_enable)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Expected {data, sending, sd_enable} after each upcoming rising edge.
   logic [9:0] exp_q[$];

   // Reference model: a packet is a list of bytes still to be handed over,
   // optionally followed by a payload phase that lasts until the source is empty.
   logic [7:0] m_bytes[$];
   bit         m_data_pkt;
   bit         m_payload;

   function automatic void model_reset();
      m_bytes.delete();
      m_data_pkt = 1'b0;
      m_payload  = 1'b0;
   endfunction

   function automatic logic [9:0] model_out();
      if (m_payload)           return {8'h00, 1'b1, 1'b1};
      if (m_bytes.size() > 0)  return {m_bytes[0], 1'b1, 1'b0};
      return 10'd0;
   endfunction

   function automatic void model_step(input bit bad, good, tx, le, emp);
      logic [7:0] taken;
      if (m_payload) begin
         if (emp) m_payload = 1'b0;
      end else if (m_bytes.size() > 0) begin
         if (le) begin
            taken = m_bytes.pop_front();
            if (m_bytes.size() == 0 && m_data_pkt && !emp) m_payload = 1'b1;
         end
      end else if (bad) begin
         m_bytes = {8'h80, 8'h5A};
         m_data_pkt = 1'b0;
      end else if (good) begin
         m_bytes = {8'h80, 8'hD2};
         m_data_pkt = 1'b0;
      end else if (tx) begin
         m_bytes = {8'h80, 8'hC3};
         m_data_pkt = 1'b1;
      end
   endfunction

   task automatic chk(input string name, input logic [9:0] got, input logic [9:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got data=%h sending=%b sd_enable=%b, expected data=%h sending=%b sd_enable=%b",
                  name, got[9:2], got[1], got[0], expv[9:2], expv[1], expv[0]);
      end
   endtask

   // Drive one cycle's inputs at the falling edge and record what the
   // outputs must be after the following rising edge.
   task automatic cycle(input bit bad, good, tx, le, emp);
      @(negedge clk);
      tx_send_bad  = bad;
      tx_send_good = good;
      tx_transmit  = tx;
      load_enable  = le;
      empty        = emp;
      model_step(bad, good, tx, le, emp);
      exp_q.push_back(model_out());
   endtask

   task automatic async_reset();
      @(negedge clk);
      {tx_send_bad, tx_send_good, tx_transmit, load_enable, empty} = '0;
      #2 n_rst = 1'b1;
      #1 chk("async_reset", {data, sending, sd_enable}, 10'd0);
      model_reset();
      exp_q.push_back(model_out());
      @(negedge clk);
      n_rst = 1'b0;
      model_step(0, 0, 0, 0, 0);
      exp_q.push_back(model_out());
   endtask

   // Monitor: compares the DUT outputs after every rising edge against the
   // expectation queued for that edge.
   initial begin
      logic [9:0] e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("outputs", {data, sending, sd_enable}, e);
         end
      end
   end

   initial begin
      bit bad, good, tx, le, emp;
      n_rst = 1'b1;
      {tx_send_bad, tx_send_good, tx_transmit, load_enable, empty} = '0;
      model_reset();
      #2 chk("reset_state", {data, sending, sd_enable}, 10'd0);
      @(negedge clk);
      n_rst = 1'b0;
      exp_q.push_back(model_out());

      // ACK packet, with a stalled SYNC byte
      cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0);

      // NAK wins over a simultaneous data request
      cycle(1, 0, 1, 0, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0);

      // Data packet with 3 payload strobes, then empty (with a strobe)
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 1);
      cycle(0, 0, 0, 0, 0);

      // Zero-length data packet
      cycle(0, 0, 1, 0, 1);
      cycle(0, 0, 0, 1, 1);
      cycle(0, 0, 0, 1, 1);
      cycle(0, 0, 0, 0, 1);

      // ACK request during SYNC of a data packet is ignored
      cycle(0, 0, 1, 0, 0);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);

      // load_enable in IDLE does nothing
      cycle(0, 0, 0, 1, 0);

      // Asynchronous reset in the middle of a payload phase
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);
      async_reset();
      cycle(0, 0, 0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bad  = ($urandom_range(0, 15) == 0);
         good = ($urandom_range(0, 7) == 0);
         tx   = ($urandom_range(0, 3) == 0);
         le   = ($urandom_range(0, 9) < 4);
         emp  = ($urandom_range(0, 9) < 2);
         cycle(bad, good, tx, le, emp);
         if (i % 700 == 350) async_reset();
      end

      @(posedge clk);
      #3;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
